// File: rtl/mux_serializer.sv
// ---------------------------------------------------------------------------
// mux_serializer
//
// Parallel-in / serial-out stage that sits in front of an external `mux`.
// A 2**SEL_WIDTH-bit word is accepted over a valid/ready handshake, then
// emitted one bit per downstream transfer while a registered select counter
// walks every index. The running select is exported so an external `mux`
// instance can be driven in lock-step with the bit chosen internally.
//
// Parameters:
//   SEL_WIDTH        select width (legal 1..6); word width is 2**SEL_WIDTH
//
// Build option:
//   MUX_SERIALIZER_MSB_FIRST_EN  when defined, bits leave MSB first (select
//                                counts down from 2**SEL_WIDTH-1 to 0);
//                                otherwise LSB first (counts up from 0).
//
// Ports:
//   i_w_clk        in   clock, all state on the rising edge
//   i_w_rst_n      in   asynchronous reset, active-low
//   i_w_in         in   parallel word to serialize
//   i_w_in_valid   in   upstream word valid
//   o_w_in_ready   out  block can accept a word this cycle
//   o_w_sel        out  current select index (registered)
//   o_w_out        out  current serial bit = captured word[o_w_sel]
//   o_w_out_valid  out  o_w_out holds a valid bit
//   i_w_out_ready  in   downstream accepts the bit this cycle
//   o_w_last       out  current bit is the final bit of the word
//   o_w_busy       out  a word is held
// ---------------------------------------------------------------------------
module mux_serializer #(
  parameter int SEL_WIDTH = 3
) (
  input  logic                      i_w_clk,
  input  logic                      i_w_rst_n,
  input  logic [(1<<SEL_WIDTH)-1:0] i_w_in,
  input  logic                      i_w_in_valid,
  output logic                      o_w_in_ready,
  output logic [SEL_WIDTH-1:0]      o_w_sel,
  output logic                      o_w_out,
  output logic                      o_w_out_valid,
  input  logic                      i_w_out_ready,
  output logic                      o_w_last,
  output logic                      o_w_busy
);

  localparam int WIDTH = 1 << SEL_WIDTH;

  localparam logic [SEL_WIDTH-1:0] SEL_ZERO = '0;
  localparam logic [SEL_WIDTH-1:0] SEL_ONES = '1;
  localparam logic [SEL_WIDTH-1:0] SEL_STEP = SEL_WIDTH'(1);

`ifdef MUX_SERIALIZER_MSB_FIRST_EN
  localparam logic [SEL_WIDTH-1:0] SEL_FIRST = SEL_ONES;
  localparam logic [SEL_WIDTH-1:0] SEL_LAST  = SEL_ZERO;
`else
  localparam logic [SEL_WIDTH-1:0] SEL_FIRST = SEL_ZERO;
  localparam logic [SEL_WIDTH-1:0] SEL_LAST  = SEL_ONES;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     word_q, word_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] sel_next;

  logic sending;
  logic at_last;
  logic bit_xfer;
  logic in_ready;
  logic word_load;

  // The counter only ever moves towards SEL_LAST and is reloaded before it
  // could wrap, so a plain add/subtract is enough.
`ifdef MUX_SERIALIZER_MSB_FIRST_EN
  assign sel_next = sel_q - SEL_STEP;
`else
  assign sel_next = sel_q + SEL_STEP;
`endif

  assign sending  = (state_q == SEND);
  assign at_last  = sending && (sel_q == SEL_LAST);
  assign bit_xfer = sending && i_w_out_ready;

  // Ready also opens while the final bit is leaving, so the next word can be
  // captured on the same edge and the output stream has no bubble. This is
  // a deliberate combinational path from i_w_out_ready.
  assign in_ready  = !sending || (at_last && i_w_out_ready);
  assign word_load = i_w_in_valid && in_ready;

  // State, captured word and select counter all reset asynchronously so a
  // word in flight is dropped immediately.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      sel_q   <= SEL_ZERO;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic. A stalled SEND (no downstream ready) falls through the
  // defaults and keeps word and select frozen, so the offered bit never
  // changes or disappears until it is taken.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (word_load) begin
          word_d  = i_w_in;
          sel_d   = SEL_FIRST;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bit_xfer) begin
          if (!at_last) begin
            sel_d = sel_next;
          end else if (word_load) begin
            word_d = i_w_in;
            sel_d  = SEL_FIRST;
          end else begin
            sel_d   = SEL_FIRST;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_ZERO;
      end
    endcase
  end

  // o_w_last is qualified by SEND because in the MSB-first build SEL_LAST is
  // zero, which is also the idle/reset select value.
  assign o_w_in_ready  = in_ready;
  assign o_w_sel       = sel_q;
  assign o_w_out       = word_q[sel_q];
  assign o_w_out_valid = sending;
  assign o_w_last      = at_last;
  assign o_w_busy      = sending;

endmodule

// File: tb/tb_mux_serializer.sv
// ---------------------------------------------------------------------------
// tb_mux_serializer
//
// Self-checking bench for mux_serializer (SEL_WIDTH=3). A reference model
// keeps a queue of the bits each accepted word must produce (value, select
// and last flag), derived straight from the word and the bit ordering.
// Honours MUX_SERIALIZER_MSB_FIRST_EN for the expected ordering.
// ---------------------------------------------------------------------------
module tb_mux_serializer;

  localparam int SW = 3;
  localparam int W  = 1 << SW;

`ifdef MUX_SERIALIZER_MSB_FIRST_EN
  localparam int FIRST_IDX = W - 1;
`else
  localparam int FIRST_IDX = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_word;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] sel;
  logic          out_bit;
  logic          out_valid;
  logic          out_ready;
  logic          last;
  logic          busy;

  mux_serializer #(.SEL_WIDTH(SW)) dut (
    .i_w_clk       (clk),
    .i_w_rst_n     (rst_n),
    .i_w_in        (in_word),
    .i_w_in_valid  (in_valid),
    .o_w_in_ready  (in_ready),
    .o_w_sel       (sel),
    .o_w_out       (out_bit),
    .o_w_out_valid (out_valid),
    .i_w_out_ready (out_ready),
    .o_w_last      (last),
    .o_w_busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    int   idx;
    logic lst;
  } beat_t;

  beat_t      exp_q[$];
  int         idle_sel;
  logic [W-1:0] pend_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Expand an accepted word into the bits it must produce, in order.
  task automatic pushWord(input logic [W-1:0] w);
    beat_t bt;
    for (int k = 0; k < W; k++) begin
`ifdef MUX_SERIALIZER_MSB_FIRST_EN
      bt.idx = W - 1 - k;
`else
      bt.idx = k;
`endif
      bt.b   = w[bt.idx];
      bt.lst = (k == W - 1);
      exp_q.push_back(bt);
    end
  endtask

  task automatic checkAll(input logic r);
    if (exp_q.size() == 0) begin
      checkOutput("idle_valid", 32'(out_valid), 32'd0);
      checkOutput("idle_busy",  32'(busy),      32'd0);
      checkOutput("idle_last",  32'(last),      32'd0);
      checkOutput("idle_sel",   32'(sel),       32'(idle_sel));
      checkOutput("idle_ready", 32'(in_ready),  32'd1);
    end else begin
      checkOutput("send_valid", 32'(out_valid), 32'd1);
      checkOutput("send_busy",  32'(busy),      32'd1);
      checkOutput("send_sel",   32'(sel),       32'(exp_q[0].idx));
      checkOutput("send_bit",   32'(out_bit),   32'(exp_q[0].b));
      checkOutput("send_last",  32'(last),      32'(exp_q[0].lst));
      checkOutput("send_ready", 32'(in_ready),  32'((exp_q.size() == 1) && r));
    end
  endtask

  // One clock: drive at the falling edge, check just after, then advance
  // the model on the rising edge. Reports whether the word was taken.
  task automatic applyStimulus(input logic v, input logic [W-1:0] w, input logic r,
                               output logic accepted);
    logic can_take;
    @(negedge clk);
    in_valid  = v;
    in_word   = w;
    out_ready = r;
    #1;
    checkAll(r);
    can_take = (exp_q.size() == 0) || ((exp_q.size() == 1) && r);
    accepted = v && can_take;
    @(posedge clk);
    if (exp_q.size() > 0 && r) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) idle_sel = FIRST_IDX;
    end
    if (accepted) pushWord(w);
  endtask

  // Feed pend_q with upstream holding valid until accepted; bounded.
  task automatic runQueue(input int ready_pct, input int idle_pct);
    logic holding = 1'b0;
    logic v, r, acc;
    int   cyc = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && cyc < 5000) begin
      v = (pend_q.size() > 0) && (holding || ($urandom_range(99) >= idle_pct));
      r = ($urandom_range(99) < ready_pct);
      applyStimulus(v, v ? pend_q[0] : '0, r, acc);
      if (acc) void'(pend_q.pop_front());
      holding = v && !acc;
      cyc++;
    end
    if (cyc >= 5000) checkOutput("drain_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_busy"},  32'(busy),      32'd0);
    checkOutput({tag, "_last"},  32'(last),      32'd0);
    checkOutput({tag, "_sel"},   32'(sel),       32'd0);
    checkOutput({tag, "_out"},   32'(out_bit),   32'd0);
    checkOutput({tag, "_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    logic acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b0;
    idle_sel  = 0;

    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Alternating word, downstream always ready.
    $display("[TB] alternating word, full rate");
    pend_q.push_back(8'hAA);
    runQueue(100, 0);
    applyStimulus(1'b0, '0, 1'b1, acc);

    // Stall three cycles after the first bit has gone.
    $display("[TB] stall mid-word");
    applyStimulus(1'b1, 8'hAA, 1'b1, acc);
    checkOutput("stall_load_acc", 32'(acc), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, acc);
    repeat (3) applyStimulus(1'b0, '0, 1'b0, acc);
    for (int k = 0; k < W - 1; k++) applyStimulus(1'b0, '0, 1'b1, acc);
    applyStimulus(1'b0, '0, 1'b1, acc);

    // Back-to-back words with valid held: no bubble between them.
    $display("[TB] back-to-back words");
    pend_q.push_back(8'h01);
    pend_q.push_back(8'h80);
    runQueue(100, 0);

    // Reset in the middle of a word.
    $display("[TB] reset mid-word");
    applyStimulus(1'b1, 8'h5C, 1'b1, acc);
    repeat (2) applyStimulus(1'b0, '0, 1'b1, acc);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("midrst");
    exp_q.delete();
    idle_sel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) applyStimulus(1'b0, '0, 1'b1, acc);

    // Every one-hot word.
    $display("[TB] one-hot sweep");
    for (int i = 0; i < W; i++) begin
      logic [W-1:0] oh;
      oh = '0;
      oh[i] = 1'b1;
      pend_q.push_back(oh);
    end
    runQueue(100, 0);

    // Random words, random gaps and random downstream back-pressure.
    $display("[TB] randomized traffic");
    for (int i = 0; i < 150; i++) pend_q.push_back(W'($urandom));
    runQueue(70, 30);
    for (int i = 0; i < 50; i++) pend_q.push_back(W'($urandom));
    runQueue(100, 0);
    repeat (2) applyStimulus(1'b0, '0, 1'($urandom), acc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
